// File: rtl/spi_master_apb_if.sv
// APB register-bus bundle for spi_master_apb; master drives the request, slave answers.
interface spi_master_apb_if #(
    parameter int DW = 8
);
    logic          psel_i;
    logic          penable_i;
    logic          pwrite_i;
    logic [7:0]    paddr_i;
    logic [DW-1:0] pwdata_i;
    logic [DW-1:0] prdata_o;
    logic          pready_o;
    logic          perror_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, perror_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, perror_o
    );
endinterface

// File: rtl/spi_master_apb.sv
// Batch SPI master behind a zero-wait APB register file.
// Optional feature: define SPI_LOOPBACK_EN to implement the CSSEL[7] internal loopback.
module spi_master_apb #(
    parameter int DW        = 8,
    parameter int NUM_TXS   = 8,
    parameter int NUM_CS    = 3,
    parameter int GAP_SCLKS = 5
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    spi_master_apb_if.slave   apb,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [NUM_CS-1:0] cs_n_o
);
    localparam int SW   = (NUM_TXS > 1) ? $clog2(NUM_TXS) : 1;
    localparam int PMAX = (DW > GAP_SCLKS + 1) ? DW : GAP_SCLKS + 1;
    localparam int CW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(DW);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ADDR, S_GAP, S_DATA, S_HOLD} state_t;
    state_t state_reg, state_next;

    logic [DW-1:0]     addr_mem  [NUM_TXS];
    logic [DW-1:0]     data_mem  [NUM_TXS];
    logic [DW-1:0]     rdata_mem [NUM_TXS];
    logic              cpol_reg, cpha_reg, lsb_reg, done_reg, half_reg;
    logic [3:0]        count_reg, slot_reg, last_slot;
    logic [7:0]        clkdiv_reg, div_cnt_reg;
    logic [2:0]        cs_idx_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [DW-1:0]     rx_reg, rx_next, tx_word, rd_data;
    logic [NUM_CS-1:0] cs_n_reg, cs_sel;
    logic [BW-1:0]     bit_pos;
    logic [SW-1:0]     slot_idx, cur_slot;
    logic              acc, wr, err, wr_ok, busy, start_wr, mapped, lb_en, miso_int;
    logic              hit_addr, hit_data, hit_rdata, hit_ctrl, hit_stat, hit_div, hit_cssel;
    logic              half_tick, per_end, mid_tick, sample_tick, rx_done, is_rd_tx;

    // ---------------- APB decode ----------------
    assign acc       = apb.psel_i && apb.penable_i;
    assign wr        = acc && apb.pwrite_i;
    assign slot_idx  = apb.paddr_i[SW-1:0];
    assign hit_addr  = (apb.paddr_i[7:5] == 3'd0) && (int'(apb.paddr_i[4:0]) < NUM_TXS);
    assign hit_data  = (apb.paddr_i[7:5] == 3'd1) && (int'(apb.paddr_i[4:0]) < NUM_TXS);
    assign hit_rdata = (apb.paddr_i[7:5] == 3'd2) && (int'(apb.paddr_i[4:0]) < NUM_TXS);
    assign hit_ctrl  = (apb.paddr_i == 8'h60);
    assign hit_stat  = (apb.paddr_i == 8'h61);
    assign hit_div   = (apb.paddr_i == 8'h62);
    assign hit_cssel = (apb.paddr_i == 8'h63);
    assign busy      = (state_reg != S_IDLE);

    always_comb begin
        mapped = hit_addr | hit_data | hit_rdata | hit_ctrl | hit_stat | hit_div | hit_cssel;
        err    = !mapped;
        if (apb.pwrite_i) begin
            if (hit_rdata) err = 1'b1;
            if (hit_cssel && (int'(apb.pwdata_i[2:0]) >= NUM_CS)) err = 1'b1;
            // STATUS stays writable while busy so software can clear DONE
            if (busy && (hit_addr | hit_data | hit_ctrl | hit_div | hit_cssel)) err = 1'b1;
        end
    end

    assign wr_ok    = wr && !err;
    assign start_wr = wr_ok && hit_ctrl && apb.pwdata_i[0];

    always_comb begin
        rd_data = '0;
        if (hit_addr)  rd_data = addr_mem[slot_idx];
        if (hit_data)  rd_data = data_mem[slot_idx];
        if (hit_rdata) rd_data = rdata_mem[slot_idx];
        if (hit_ctrl)  rd_data = DW'({count_reg, lsb_reg, cpha_reg, cpol_reg, 1'b0});
        if (hit_stat)  rd_data = DW'({slot_reg, 2'b00, done_reg, busy});
        if (hit_div)   rd_data = DW'(clkdiv_reg);
        if (hit_cssel) rd_data = DW'({lb_en, 4'b0000, cs_idx_reg});
    end

    assign apb.pready_o = acc;
    assign apb.perror_o = acc && err;
    assign apb.prdata_o = (acc && !apb.pwrite_i && !err) ? rd_data : '0;

`ifdef SPI_LOOPBACK_EN
    logic lb_reg;
    always_ff @(posedge pclk_i) begin
        if (prst_i)                 lb_reg <= 1'b0;
        else if (wr_ok && hit_cssel) lb_reg <= apb.pwdata_i[7];
    end
    assign lb_en = lb_reg;
`else
    assign lb_en = 1'b0;
`endif

    // ---------------- register file ----------------
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int i = 0; i < NUM_TXS; i++) begin
                addr_mem[i]  <= '0;
                data_mem[i]  <= '0;
                rdata_mem[i] <= '0;
            end
            {count_reg, lsb_reg, cpha_reg, cpol_reg} <= '0;
            clkdiv_reg <= '0;
            cs_idx_reg <= '0;
        end else begin
            if (wr_ok && hit_addr) addr_mem[slot_idx] <= apb.pwdata_i;
            if (wr_ok && hit_data) data_mem[slot_idx] <= apb.pwdata_i;
            // with CPHA=1 the final sample lands on the same edge the phase ends
            if (rx_done)           rdata_mem[cur_slot] <= cpha_reg ? rx_next : rx_reg;
            if (wr_ok && hit_ctrl) {count_reg, lsb_reg, cpha_reg, cpol_reg} <= apb.pwdata_i[7:1];
            if (wr_ok && hit_div)  clkdiv_reg <= apb.pwdata_i[7:0];
            if (wr_ok && hit_cssel) cs_idx_reg <= apb.pwdata_i[2:0];
        end
    end

    // ---------------- SPI engine ----------------
    assign half_tick   = busy && (div_cnt_reg == clkdiv_reg);
    assign per_end     = half_tick && half_reg;
    assign mid_tick    = half_tick && !half_reg;
    assign cur_slot    = slot_reg[SW-1:0];
    assign last_slot   = (int'(count_reg) >= NUM_TXS) ? 4'(NUM_TXS - 1) : count_reg;
    assign is_rd_tx    = !addr_mem[cur_slot][DW-1];
    assign sample_tick = (state_reg == S_DATA) && (cpha_reg ? per_end : mid_tick);
    assign rx_done     = (state_reg == S_DATA) && (state_next == S_HOLD) && is_rd_tx;
    assign bit_pos     = lsb_reg ? bit_cnt_reg[BW-1:0] : BW'(DW - 1) - bit_cnt_reg[BW-1:0];
    assign miso_int    = lb_en ? mosi_o : miso_i;
    assign rx_next     = lsb_reg ? {miso_int, rx_reg[DW-1:1]} : {rx_reg[DW-2:0], miso_int};

    always_comb begin
        state_next = state_reg;
        tx_word    = '1;
        sclk_o     = cpol_reg;
        mosi_o     = 1'b1;
        case (state_reg)
            S_IDLE:  if (start_wr) state_next = S_SETUP;
            S_SETUP: if (per_end) state_next = S_ADDR;
            S_ADDR: begin
                tx_word = addr_mem[cur_slot];
                if (per_end && bit_cnt_reg == CW'(DW - 1)) state_next = S_GAP;
            end
            S_GAP:   if (per_end && bit_cnt_reg == CW'(GAP_SCLKS - 1)) state_next = S_DATA;
            S_DATA: begin
                tx_word = is_rd_tx ? '1 : data_mem[cur_slot];
                if (per_end && bit_cnt_reg == CW'(DW - 1)) state_next = S_HOLD;
            end
            // one extra period in HOLD rounds a transaction to 2+2*DW+2*GAP_SCLKS periods
            S_HOLD:  if (per_end && bit_cnt_reg == CW'(GAP_SCLKS))
                         state_next = (slot_reg == last_slot) ? S_IDLE : S_SETUP;
            default: state_next = S_IDLE;
        endcase
        if (state_reg == S_ADDR || state_reg == S_DATA) begin
            sclk_o = cpol_reg ^ cpha_reg ^ half_reg;
            mosi_o = tx_word[bit_pos];
        end
    end

    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
        assign cs_sel[gi] = (int'(cs_idx_reg) == gi);
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_reg   <= S_IDLE;
            div_cnt_reg <= '0;
            half_reg    <= 1'b0;
            bit_cnt_reg <= '0;
            slot_reg    <= '0;
            rx_reg      <= '0;
            done_reg    <= 1'b0;
            cs_n_reg    <= '1;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) bit_cnt_reg <= '0;
            else if (per_end)            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (!busy || half_tick) div_cnt_reg <= '0;
            else                    div_cnt_reg <= div_cnt_reg + 8'd1;
            if (!busy)          half_reg <= 1'b0;
            else if (half_tick) half_reg <= ~half_reg;
            if (start_wr) slot_reg <= '0;
            else if (state_reg == S_HOLD && state_next == S_SETUP) slot_reg <= slot_reg + 4'd1;
            if (sample_tick) rx_reg <= rx_next;
            if (state_reg == S_HOLD && state_next == S_IDLE)     done_reg <= 1'b1;
            else if (wr_ok && hit_stat && apb.pwdata_i[1])       done_reg <= 1'b0;
            // chip select trails the state by one pclk
            if ((state_reg == S_SETUP || state_reg == S_ADDR || state_reg == S_GAP ||
                 state_reg == S_DATA) && !lb_en)
                cs_n_reg <= ~cs_sel;
            else
                cs_n_reg <= '1;
        end
    end

    assign cs_n_o = cs_n_reg;
endmodule

// File: tb/tb_spi_master_apb.sv
// Directed self-checking bench for spi_master_apb (DW=8, NUM_TXS=8, NUM_CS=3, GAP_SCLKS=5).
module tb_spi_master_apb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk, mosi, miso = 1'b1;
    logic [2:0] cs_n;
    int         total = 0;
    int         bad = 0;

    spi_master_apb_if #(.DW(8)) bus ();

    spi_master_apb #(.DW(8), .NUM_TXS(8), .NUM_CS(3), .GAP_SCLKS(5)) dut (
        .pclk_i(clk), .prst_i(rst), .apb(bus.slave),
        .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
    );

    always #5 clk = ~clk;

    // Slave on chip select 2: returns 0xA5 LSB first during the data phase, changing on falling SCLK.
    int         fcnt = 0;
    logic [7:0] spat = 8'hA5;
    always @(negedge sclk or posedge cs_n[2]) begin
        if (cs_n[2] !== 1'b0) fcnt = 0;
        else begin
            fcnt++;
            if (fcnt >= 9 && fcnt <= 16) miso = spat[fcnt-9];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, input logic exp_err, input string tag);
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = a; bus.pwdata_i = d;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        @(negedge clk);
        chk({tag, ".pready"}, 32'(bus.pready_o), 32'd1);
        chk({tag, ".perror"}, 32'(bus.perror_o), 32'(exp_err));
        $display("wr  a=%02h d=%02h perror=%0b", a, d, bus.perror_o);
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_err, input string tag);
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = a;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        @(negedge clk);
        chk({tag, ".prdata"}, 32'(bus.prdata_o), 32'(exp_d));
        chk({tag, ".perror"}, 32'(bus.perror_o), 32'(exp_err));
        $display("rd  a=%02h d=%02h perror=%0b", a, bus.prdata_o, bus.perror_o);
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    endtask

    int          rises, cs_low, gap_bad, cs_bad, cs_falls;
    logic        prev_sclk, prev_cs;
    logic [15:0] cap;

    initial begin
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.sclk", 32'(sclk), 32'd0);
        chk("rst.mosi", 32'(mosi), 32'd1);
        chk("rst.cs_n", 32'(cs_n), 32'h7);
        chk("rst.pready", 32'(bus.pready_o), 32'd0);
        chk("rst.perror", 32'(bus.perror_o), 32'd0);
        chk("rst.prdata", 32'(bus.prdata_o), 32'd0);
        apb_rd(8'h61, 8'h00, 1'b0, "rst.status");

        // Mode 0 write transaction on slave 2
        apb_wr(8'h62, 8'h01, 1'b0, "t1.clkdiv");
        apb_wr(8'h63, 8'h02, 1'b0, "t1.cssel");
        apb_wr(8'h00, 8'h85, 1'b0, "t1.addr0");
        apb_wr(8'h20, 8'h3C, 1'b0, "t1.data0");
        apb_wr(8'h60, 8'h01, 1'b0, "t1.ctrl");
        rises = 0; cs_low = 0; gap_bad = 0; cs_bad = 0; cap = '0; prev_sclk = 1'b0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                cap = {cap[14:0], mosi};
            end
            prev_sclk = sclk;
            if (cs_n === 3'b011) cs_low++;
            else if (cs_n !== 3'b111) cs_bad++;
            if (k >= 36 && k <= 55 && (mosi !== 1'b1 || sclk !== 1'b0)) gap_bad++;
        end
        chk("t1.mosi_bits", 32'(cap), 32'h853C);
        chk("t1.sclk_rises", 32'(rises), 32'd16);
        chk("t1.cs_low_cycles", 32'(cs_low), 32'd88);
        chk("t1.cs_other", 32'(cs_bad), 32'd0);
        chk("t1.gap_idle", 32'(gap_bad), 32'd0);
        apb_rd(8'h61, 8'h01, 1'b0, "t1.status_busy");
        apb_rd(8'h61, 8'h02, 1'b0, "t1.status_done");
        apb_wr(8'h61, 8'h02, 1'b0, "t1.done_clr");
        apb_rd(8'h61, 8'h00, 1'b0, "t1.status_clr");

        // Mode 3, LSB first, two slots; slot 1 reads from the slave model
        apb_wr(8'h01, 8'h12, 1'b0, "t2.addr1");
        apb_wr(8'h60, 8'h1F, 1'b0, "t2.ctrl");
        cs_falls = 0; prev_cs = 1'b1;
        for (int k = 0; k < 230; k++) begin
            @(negedge clk);
            if (k == 0) chk("t2.sclk_idle_setup", 32'(sclk), 32'd1);
            if (cs_n[2] === 1'b0 && prev_cs === 1'b1) cs_falls++;
            prev_cs = cs_n[2];
        end
        chk("t2.cs_falls", 32'(cs_falls), 32'd2);
        chk("t2.sclk_idle_end", 32'(sclk), 32'd1);
        apb_rd(8'h61, 8'h12, 1'b0, "t2.status");
        apb_rd(8'h41, 8'hA5, 1'b0, "t2.rdata1");
        apb_rd(8'h40, 8'h00, 1'b0, "t2.rdata0_held");
        apb_rd(8'h60, 8'h1E, 1'b0, "t2.ctrl_rb");

        // Writes while busy are rejected
        apb_wr(8'h61, 8'h02, 1'b0, "t3.done_clr");
        apb_wr(8'h60, 8'h01, 1'b0, "t3.start");
        apb_wr(8'h00, 8'h55, 1'b1, "t3.addr_busy");
        apb_wr(8'h60, 8'h01, 1'b1, "t3.ctrl_busy");
        apb_rd(8'h00, 8'h85, 1'b0, "t3.addr0_kept");
        apb_rd(8'h61, 8'h01, 1'b0, "t3.status_busy");
        repeat (120) @(negedge clk);
        apb_rd(8'h61, 8'h02, 1'b0, "t3.status_done");

        // Address and value errors
        apb_rd(8'h70, 8'h00, 1'b1, "t4.unmapped");
        apb_rd(8'h08, 8'h00, 1'b1, "t4.slot_oob");
        apb_wr(8'h63, 8'h05, 1'b1, "t4.cssel5");
        apb_rd(8'h63, 8'h02, 1'b0, "t4.cssel_kept");
        apb_wr(8'h40, 8'h11, 1'b1, "t4.rdata_wr");
        apb_rd(8'h40, 8'h00, 1'b0, "t4.rdata_kept");

        // Reset during the data phase
        apb_wr(8'h61, 8'h02, 1'b0, "t5.done_clr");
        apb_wr(8'h60, 8'h01, 1'b0, "t5.start");
        repeat (57) @(negedge clk);
        chk("t5.pre_mosi", 32'(mosi), 32'd0);
        chk("t5.pre_cs", 32'(cs_n), 32'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5.cs_n", 32'(cs_n), 32'h7);
        chk("t5.mosi", 32'(mosi), 32'd1);
        chk("t5.sclk", 32'(sclk), 32'd0);
        rst = 1'b0;
        apb_rd(8'h61, 8'h00, 1'b0, "t5.status");
        apb_rd(8'h41, 8'h00, 1'b0, "t5.rdata1");
        apb_rd(8'h62, 8'h00, 1'b0, "t5.clkdiv");

`ifdef SPI_LOOPBACK_EN
        apb_wr(8'h00, 8'h12, 1'b0, "t6.addr0");
        apb_wr(8'h63, 8'h80, 1'b0, "t6.cssel");
        apb_rd(8'h63, 8'h80, 1'b0, "t6.cssel_rb");
        apb_wr(8'h60, 8'h01, 1'b0, "t6.start");
        cs_bad = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (cs_n !== 3'b111) cs_bad++;
        end
        chk("t6.cs_high", 32'(cs_bad), 32'd0);
        apb_rd(8'h40, 8'hFF, 1'b0, "t6.rdata0");
        apb_rd(8'h61, 8'h02, 1'b0, "t6.status");
`else
        apb_wr(8'h63, 8'h80, 1'b0, "t6.cssel_lb");
        apb_rd(8'h63, 8'h00, 1'b0, "t6.cssel_rb");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
